wb_register_simulink2ppc_snap: RTL

- Wishbone slave register carrying data from user (Simulink) fabric logic to the processor.
- User logic presents a word with a valid strobe. The block latches it and flags new data, and counts captures and overruns.
- Two capture modes: continuous (latest sample wins) and one-shot armed snapshot.
- Single clock domain; sits on the wishbone bus alongside the processor-to-fabric registers.

---
 rtl/wb_snap_pkg.sv | 24 ++
 rtl/wb_snap_sat_counter.sv | 22 ++
 rtl/wb_register_simulink2ppc_snap.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/wb_snap_pkg.sv
// Shared definitions for the fabric-to-processor snapshot register:
// register offsets, register bit positions and the one-shot capture states.
package wb_snap_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CAPCNT = 2'd3;

    localparam int STATUS_VALID_BIT   = 0;
    localparam int STATUS_OVERRUN_BIT = 1;
    localparam int STATUS_OVR_CNT_LSB = 16;

    localparam int CTRL_MODE_BIT     = 0;
    localparam int CTRL_ARM_BIT      = 1;
    localparam int CTRL_CAPTURED_BIT = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        CAPTURED = 2'd2
    } snap_state_t;

endpackage

// File: rtl/wb_snap_sat_counter.sv
// Saturating up-counter with a clear that takes priority over increment.
module wb_snap_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/wb_register_simulink2ppc_snap.sv
// Wishbone slave register carrying fabric (Simulink) samples to the processor,
// with continuous or one-shot armed capture plus capture and overrun counters.
module wb_register_simulink2ppc_snap
    import wb_snap_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OVR_WIDTH  = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_n_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [31:0]           wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    input  logic [DATA_WIDTH-1:0] user_data_in,
    input  logic                  user_valid_in,
    output logic                  user_armed_out
);

    snap_state_t          state;
    snap_state_t          state_next;
    logic                 ack;
    logic [31:0]          data_reg;
    logic [31:0]          cap_cnt;
    logic                 valid;
    logic                 overrun;
    logic                 mode;
    logic [OVR_WIDTH-1:0] ovr_cnt;
    logic [1:0]           addr;
    logic                 access;
    logic                 wr;
    logic                 rd;
    logic                 wr_ctrl;
    logic                 wr_status;
    logic                 data_rd;
    logic                 ovr_clr;
    logic                 arm_req;
    logic                 mode_off;
    logic                 cap;
    logic                 ovr_evt;
    logic [31:0]          rd_word;
    logic                 unused_bits;

    assign addr      = wb_adr_i[3:2];
    assign access    = wb_cyc_i & wb_stb_i & ~ack;
    assign wr        = access & wb_we_i;
    assign rd        = access & ~wb_we_i;
    assign wr_ctrl   = wr & (addr == ADDR_CTRL) & wb_sel_i[0];
    assign wr_status = wr & (addr == ADDR_STATUS) & wb_sel_i[0];
    assign data_rd   = rd & (addr == ADDR_DATA);
    assign ovr_clr   = wr_status & wb_dat_i[STATUS_OVERRUN_BIT];
    assign arm_req   = wr_ctrl & wb_dat_i[CTRL_ARM_BIT] & wb_dat_i[CTRL_MODE_BIT];
    assign mode_off  = wr_ctrl & ~wb_dat_i[CTRL_MODE_BIT];

    // An arm write landing with a strobe while idle wins: that strobe is dropped.
    assign cap     = user_valid_in & (mode ? (state == ARMED) : ~arm_req);
    assign ovr_evt = cap & ~mode & valid;

    assign wb_ack_o       = ack;
    assign wb_err_o       = 1'b0;
    assign user_armed_out = (state == ARMED);
    assign unused_bits    = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_sel_i[3:1], wb_dat_i[31:3]};

    wb_snap_sat_counter #(
        .WIDTH(OVR_WIDTH)
    ) u_ovr_cnt (
        .clk  (wb_clk_i),
        .rst_n(wb_rst_n_i),
        .inc  (ovr_evt),
        .clr  (ovr_clr),
        .count(ovr_cnt)
    );

    always_comb begin
        rd_word = '0;
        unique case (addr)
            ADDR_DATA:   rd_word = data_reg;
            ADDR_STATUS: begin
                rd_word[STATUS_VALID_BIT]                     = valid;
                rd_word[STATUS_OVERRUN_BIT]                   = overrun;
                rd_word[STATUS_OVR_CNT_LSB +: 16]             = 16'(ovr_cnt);
            end
            ADDR_CTRL: begin
                rd_word[CTRL_MODE_BIT]     = mode;
                rd_word[CTRL_CAPTURED_BIT] = (state == CAPTURED);
            end
            default:     rd_word = cap_cnt;
        endcase
    end

    always_comb begin
        state_next = state;
        if (mode_off) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:     if (arm_req) state_next = ARMED;
                ARMED:    if (cap)     state_next = CAPTURED;
                CAPTURED: if (arm_req) state_next = ARMED;
                default:  state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A capture coinciding with a DATA read keeps VALID set; the reader got the old word.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack      <= 1'b0;
            wb_dat_o <= '0;
            data_reg <= '0;
            cap_cnt  <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
            mode     <= 1'b0;
        end else begin
            ack      <= access;
            wb_dat_o <= rd ? rd_word : 32'd0;
            if (cap) begin
                data_reg <= 32'(user_data_in);
                cap_cnt  <= cap_cnt + 32'd1;
            end
            if (cap) begin
                valid <= 1'b1;
            end else if (data_rd) begin
                valid <= 1'b0;
            end
            if (ovr_clr) begin
                overrun <= 1'b0;
            end else if (ovr_evt) begin
                overrun <= 1'b1;
            end
            if (wr_ctrl) begin
                mode <= wb_dat_i[CTRL_MODE_BIT];
            end
        end
    end

endmodule
